matrix_mem_port: RTL and testbench
==================================

Name: matrix_mem_port

Overview:
- Host-side access port to the 256-bit matrix RAM that the coprocessor reads operands from (addresses 1, 2) and writes results to (address 3).
- Write path: assembles 8 host words of 32 bits into one 256-bit line and writes it to RAM (loading matrix A and B).
- Read path: fetches one 256-bit line and streams it back as 8 words of 32 bits (result readback).
- Sits between the host bus and the RAM's single port. It owns the port only while the coprocessor is idle.

Parameters:
- ADDR_W, 8, RAM address width.
- RD_LAT, 1, RAM read latency in clocks from address presented to mem_rdata valid; legal range 1..3.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  host command strobe.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  00 write line, 01 read line, 10/11 illegal.
- cmd_addr  in  ADDR_W  target RAM line.
- wr_valid  in  1  host write-word strobe.
- wr_ready  out  1  high in FILL only.
- wr_data  in  32  write word.
- rd_valid  out  1  readback word valid.
- rd_ready  in  1  host accepts the readback word.
- rd_data  out  32  readback word.
- mem_address  out  ADDR_W  RAM address, registered.
- mem_wdata  out  256  RAM write data, registered.
- mem_wren  out  1  RAM write enable, registered.
- mem_rdata  in  256  RAM read data.
- cop_busy  in  1  coprocessor is using the RAM; blocks new commands.
- busy  out  1  state != IDLE; the top level gates the coprocessor start with it.
- err  out  1  one-cycle pulse when an illegal opcode is accepted.

Behaviour:
- Reset (async assert, sync deassert by the system) forces:
  - state=IDLE;
  - wr_ready, rd_valid, mem_wren, busy, err = 0;
  - rd_data, mem_address, mem_wdata = 0;
  - word counter = 0, line buffer cleared.
- Reset mid-operation abandons the partial line; no RAM write occurs.
- cmd_ready = (state==IDLE) && !cop_busy, combinational. cop_busy rising mid-operation does not abort the operation.
- Word order: word k maps to line bits [32k+31:32k]. Word 0 goes first on both paths, so matrix byte 0 sits at [7:0].
- IDLE, on accept:
  - Latch cmd_op and cmd_addr.
  - 00 -> FILL, counter=0.
  - 01 -> RD_WAIT, mem_address<=cmd_addr, mem_wren=0.
  - 10/11 -> err=1 next cycle for 1 cycle; stay IDLE.
- FILL:
  - wr_ready=1. Each wr_valid&&wr_ready stores wr_data into word[counter], then counter++.
  - On the 8th word, go to WRITE next cycle: mem_address<=addr, mem_wdata<=line, mem_wren<=1.
  - wr_valid gaps are allowed; the counter holds during them.
- WRITE:
  - mem_wren is high for exactly one cycle; next cycle mem_wren=0 and state=IDLE.
  - Write command minimum: 1 accept + 8 word cycles + 1 write cycle; cmd_ready returns the cycle after WRITE.
- RD_WAIT:
  - mem_address is stable.
  - After RD_LAT cycles counted from the first cycle mem_address holds addr, capture mem_rdata into the line buffer.
  - Then go to DRAIN with counter=0.
- DRAIN:
  - rd_valid=1, rd_data=word[counter], registered.
  - On rd_valid&&rd_ready: counter++ and rd_data advances next cycle. rd_data is held stable while rd_ready is low.
  - After the 8th handshake: rd_valid=0, go to IDLE.
- Counter is 3 bits; a wrap from 7 to 0 coincides with the state exit, never a ninth word.
- busy=1 in every state except IDLE. mem_address holds its last value in IDLE (harmless, because wren=0).
- wr_valid outside FILL and rd_ready outside DRAIN are ignored.

Decomposition:
- Shared package holds:
  - OP_WR_LINE=2'b00, OP_RD_LINE=2'b01;
  - WORDS_PER_LINE=8, WORD_W=32, LINE_W=256;
  - state encoding IDLE/FILL/WRITE/RD_WAIT/DRAIN.
  - The coprocessor top reuses LINE_W and the opcodes.
- One sub-module, matrix_line_buffer: 8x32 register file with:
  - indexed word write and indexed word read;
  - parallel 256-bit load from mem_rdata and parallel 256-bit output.
- The FSM and counters stay in matrix_mem_port.

Test Plan:
- Write line: cmd 00 addr 1, then words 0x03020100..0x1F1E1D1C with no gaps -> one mem_wren pulse, mem_address=1, mem_wdata[7:0]=0x00, [255:224]=0x1F1E1D1C; busy then drops.
- Read line with RD_LAT=1 and RD_LAT=3: RAM model holds a known line at addr 3; cmd 01 addr 3 -> rd_data returns the 8 words in order 0..7. With rd_ready toggling 1/0, no word is lost or duplicated and rd_data stays stable while stalled.
- Gated accept: cop_busy=1 with cmd_valid=1 -> cmd_ready=0, no state change. After cop_busy falls, the command is accepted the same cycle.
- Illegal op: cmd 11 -> err high exactly 1 cycle, mem_wren stays 0, state IDLE.
- Reset mid-FILL: after 5 words, pulse rst_n low -> outputs at reset values immediately, no mem_wren ever. A following full write of 8 words to addr 2 produces the correct line.
- Back-to-back: write addr 1, write addr 2, read addr 2 -> readback equals the second line; a stray wr_valid during DRAIN is ignored.

Source files
------------

// File: rtl/matrix_mem_port_pkg.sv
// Shared definitions for the matrix RAM host port.
// Contents:
//   - Opcodes OP_WR_LINE / OP_RD_LINE (also used by the coprocessor top).
//   - Line geometry: WORDS_PER_LINE x WORD_W = LINE_W.
//   - FSM state encoding state_e.
//   - op_is_legal(): true for the two defined opcodes.
package matrix_mem_port_pkg;

    localparam int WORDS_PER_LINE = 8;
    localparam int WORD_W         = 32;
    localparam int LINE_W         = 256;
    localparam int CNT_W          = 3;

    localparam logic [1:0] OP_WR_LINE = 2'b00;
    localparam logic [1:0] OP_RD_LINE = 2'b01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        WRITE   = 3'd2,
        RD_WAIT = 3'd3,
        DRAIN   = 3'd4
    } state_e;

    function automatic logic op_is_legal(input logic [1:0] op);
        return (op == OP_WR_LINE) || (op == OP_RD_LINE);
    endfunction

endpackage

// File: rtl/matrix_mem_port_if.sv
// Host-side bus of the matrix RAM port: command, write-word and
// readback-word channels.
// Every channel uses valid/ready: a transfer happens on the rising clock
// edge where both valid and ready are high; the sender keeps valid and its
// payload stable until that edge, and ready may be raised or dropped freely.
// Signals:
//   cmd_valid/cmd_ready/cmd_op/cmd_addr : command channel (host -> port)
//   wr_valid/wr_ready/wr_data           : write words (host -> port)
//   rd_valid/rd_ready/rd_data           : readback words (port -> host)
// Modports: master = host, slave = matrix_mem_port.
interface matrix_mem_port_if #(
    parameter int ADDR_W = 8
) ();
    import matrix_mem_port_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;

    logic              wr_valid;
    logic              wr_ready;
    logic [WORD_W-1:0] wr_data;

    logic              rd_valid;
    logic              rd_ready;
    logic [WORD_W-1:0] rd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, wr_valid, wr_data, rd_ready,
        input  cmd_ready, wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, wr_valid, wr_data, rd_ready,
        output cmd_ready, wr_ready, rd_valid, rd_data
    );

endinterface

// File: rtl/matrix_line_buffer.sv
// 8 x 32-bit line buffer between the host word stream and the 256-bit RAM.
// Ports:
//   clk, rst_n             : clock, async active-low reset (clears all words)
//   wr_en_i/wr_idx_i/wr_data_i : write one word at an index
//   load_en_i/load_data_i  : parallel load of a whole line (wins over wr_en_i)
//   rd_idx_i/rd_data_o     : combinational indexed word read
//   line_o                 : whole line, word k at bits [32k+31:32k]
module matrix_line_buffer
    import matrix_mem_port_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [CNT_W-1:0]  wr_idx_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              load_en_i,
    input  logic [LINE_W-1:0] load_data_i,
    input  logic [CNT_W-1:0]  rd_idx_i,
    output logic [WORD_W-1:0] rd_data_o,
    output logic [LINE_W-1:0] line_o
);

    logic [WORD_W-1:0] word_q [WORDS_PER_LINE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                word_q[i] <= '0;
            end
        end else if (load_en_i) begin
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                word_q[i] <= load_data_i[i*WORD_W +: WORD_W];
            end
        end else if (wr_en_i) begin
            word_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = word_q[rd_idx_i];

    for (genvar g = 0; g < WORDS_PER_LINE; g++) begin : g_line
        assign line_o[g*WORD_W +: WORD_W] = word_q[g];
    end

endmodule

// File: rtl/matrix_mem_port.sv
// Host access port to the 256-bit matrix RAM. Owns the RAM port only while
// the coprocessor is idle.
//   Write line: 8 host words are gathered into one line, then written with a
//   single one-cycle mem_wren_o pulse.
//   Read line : one line is fetched (RD_LAT clocks) and streamed back as 8
//   words, word 0 first.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   bus             : host command / write-word / readback channels (slave)
//   mem_address_o, mem_wdata_o, mem_wren_o : registered RAM controls
//   mem_rdata_i     : RAM read data
//   cop_busy_i      : coprocessor owns the RAM; blocks new commands
//   busy_o          : port is not IDLE
//   err_o           : one-cycle pulse after an illegal opcode is accepted
//   state_o         : current FSM state (debug)
module matrix_mem_port
    import matrix_mem_port_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    matrix_mem_port_if.slave  bus,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    output logic              mem_wren_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              cop_busy_i,
    output logic              busy_o,
    output logic              err_o,
    output state_e            state_o
);

    localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        lat_q, lat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic [WORD_W-1:0] rd_data_q, rd_data_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_wren_q, mem_wren_d;
    logic              err_q, err_d;

    logic              buf_wr_en;
    logic              buf_load_en;
    logic [CNT_W-1:0]  buf_rd_idx;
    logic [WORD_W-1:0] buf_rd_data;
    logic [LINE_W-1:0] buf_line;
    logic              cmd_fire;

    matrix_line_buffer u_line_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en_i     (buf_wr_en),
        .wr_idx_i    (cnt_q),
        .wr_data_i   (bus.wr_data),
        .load_en_i   (buf_load_en),
        .load_data_i (mem_rdata_i),
        .rd_idx_i    (buf_rd_idx),
        .rd_data_o   (buf_rd_data),
        .line_o      (buf_line)
    );

    assign bus.cmd_ready = (state_q == IDLE) && !cop_busy_i;
    assign bus.wr_ready  = (state_q == FILL);
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;
    assign cmd_fire      = bus.cmd_valid && bus.cmd_ready;

    assign mem_address_o = mem_address_q;
    assign mem_wdata_o   = mem_wdata_q;
    assign mem_wren_o    = mem_wren_q;
    assign busy_o        = (state_q != IDLE);
    assign err_o         = err_q;
    assign state_o       = state_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lat_d         = lat_q;
        addr_d        = addr_q;
        rd_valid_d    = rd_valid_q;
        rd_data_d     = rd_data_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_wren_d    = 1'b0;
        err_d         = 1'b0;
        buf_wr_en     = 1'b0;
        buf_load_en   = 1'b0;
        buf_rd_idx    = cnt_q + 3'd1;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    addr_d = bus.cmd_addr;
                    if (!op_is_legal(bus.cmd_op)) begin
                        err_d = 1'b1;
                    end else if (bus.cmd_op == OP_WR_LINE) begin
                        state_d = FILL;
                        cnt_d   = '0;
                    end else begin
                        state_d       = RD_WAIT;
                        mem_address_d = bus.cmd_addr;
                        lat_d         = '0;
                    end
                end
            end

            FILL: begin
                if (bus.wr_valid) begin
                    buf_wr_en = 1'b1;
                    cnt_d     = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        // Word 7 is still on the bus this cycle, so merge it
                        // in front of the 7 words already buffered.
                        state_d       = WRITE;
                        mem_address_d = addr_q;
                        mem_wdata_d   = {bus.wr_data, buf_line[LINE_W-WORD_W-1:0]};
                        mem_wren_d    = 1'b1;
                    end
                end
            end

            WRITE: begin
                state_d = IDLE;
            end

            RD_WAIT: begin
                // lat_q counts cycles since mem_address first held the line.
                if (lat_q == LAT_LAST) begin
                    buf_load_en = 1'b1;
                    state_d     = DRAIN;
                    cnt_d       = '0;
                    rd_valid_d  = 1'b1;
                    rd_data_d   = mem_rdata_i[WORD_W-1:0];
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end

            DRAIN: begin
                if (bus.rd_ready) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        rd_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        rd_data_d = buf_rd_data;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            lat_q         <= '0;
            addr_q        <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_wren_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lat_q         <= lat_d;
            addr_q        <= addr_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_wren_q    <= mem_wren_d;
            err_q         <= err_d;
        end
    end

endmodule

// File: tb/tb_matrix_mem_port.sv
// Bench for matrix_mem_port: two instances (RD_LAT=1 and RD_LAT=3) share the
// host stimulus; sel picks which one sees the strobes and is observed.
module tb_matrix_mem_port;
    import matrix_mem_port_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic        preload;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        rd_ready;
    logic        cop_busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0]  exp_q[$];
    logic [263:0] wexp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs and RAM models ----------------
    matrix_mem_port_if #(.ADDR_W(8)) if1 ();
    matrix_mem_port_if #(.ADDR_W(8)) if3 ();

    logic [7:0]   addr1, addr3;
    logic [255:0] wdata1, wdata3, rdata1, rdata3, p0, p1;
    logic         wren1, wren3, busy1, busy3, err1, err3;
    state_e       st1, st3;
    logic [255:0] ram1 [256];
    logic [255:0] ram3 [256];

    assign if1.cmd_valid = cmd_valid & ~sel;
    assign if3.cmd_valid = cmd_valid & sel;
    assign if1.wr_valid  = wr_valid & ~sel;
    assign if3.wr_valid  = wr_valid & sel;
    assign if1.rd_ready  = rd_ready & ~sel;
    assign if3.rd_ready  = rd_ready & sel;
    assign if1.cmd_op    = cmd_op;
    assign if3.cmd_op    = cmd_op;
    assign if1.cmd_addr  = cmd_addr;
    assign if3.cmd_addr  = cmd_addr;
    assign if1.wr_data   = wr_data;
    assign if3.wr_data   = wr_data;

    matrix_mem_port #(.ADDR_W(8), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1),
        .mem_address_o(addr1), .mem_wdata_o(wdata1), .mem_wren_o(wren1),
        .mem_rdata_i(rdata1), .cop_busy_i(cop_busy),
        .busy_o(busy1), .err_o(err1), .state_o(st1)
    );

    matrix_mem_port #(.ADDR_W(8), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3),
        .mem_address_o(addr3), .mem_wdata_o(wdata3), .mem_wren_o(wren3),
        .mem_rdata_i(rdata3), .cop_busy_i(cop_busy),
        .busy_o(busy3), .err_o(err3), .state_o(st3)
    );

    localparam logic [255:0] RES_LINE = 256'h9f9e9d9c_9b9a9998_97969594_93929190_8f8e8d8c_8b8a8988_87868584_83828180;

    always @(posedge clk) begin
        if (preload) begin
            ram1[3] <= RES_LINE;
            ram3[3] <= RES_LINE;
        end
        if (wren1) ram1[addr1] <= wdata1;
        if (wren3) ram3[addr3] <= wdata3;
        rdata1 <= ram1[addr1];
        p0     <= ram3[addr3];
        p1     <= p0;
        rdata3 <= p1;
    end

    logic         cur_cmd_ready, cur_wr_ready, cur_rd_valid, cur_busy, cur_err, cur_wren;
    logic [31:0]  cur_rd_data;
    logic [7:0]   cur_addr;
    logic [255:0] cur_wdata;
    state_e       cur_state;

    assign cur_cmd_ready = sel ? if3.cmd_ready : if1.cmd_ready;
    assign cur_wr_ready  = sel ? if3.wr_ready  : if1.wr_ready;
    assign cur_rd_valid  = sel ? if3.rd_valid  : if1.rd_valid;
    assign cur_rd_data   = sel ? if3.rd_data   : if1.rd_data;
    assign cur_busy      = sel ? busy3 : busy1;
    assign cur_err       = sel ? err3  : err1;
    assign cur_wren      = sel ? wren3 : wren1;
    assign cur_addr      = sel ? addr3 : addr1;
    assign cur_wdata     = sel ? wdata3 : wdata1;
    assign cur_state     = sel ? st3 : st1;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] mk_line(input logic [7:0] base);
        logic [255:0] l;
        for (int k = 0; k < 32; k++) l[k*8 +: 8] = base + 8'(k);
        return l;
    endfunction

    function automatic logic [255:0] rnd_line();
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    // RAM write monitor: each wren cycle must match the next expected write.
    always @(negedge clk) begin
        if (rst_n && cur_wren) begin
            if (wexp_q.size() == 0) begin
                check("wren_unexpected", 1'b1, 1'b0);
            end else begin
                logic [263:0] e;
                e = wexp_q.pop_front();
                check("wr_addr", cur_addr, e[263:256]);
                check("wr_line", cur_wdata, e[255:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_write(input logic [7:0] addr, input logic [255:0] line,
                            input bit gaps, input int pre_busy);
        int k;
        int guard;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_WR_LINE; cmd_addr = addr;
        for (int i = 0; i < pre_busy; i++) begin
            cop_busy = 1'b1;
            #1 check("gated_ready", cur_cmd_ready, 1'b0);
            @(posedge clk); #1 check("gated_state", cur_state, IDLE);
            @(negedge clk);
        end
        cop_busy = 1'b0;
        #1 check("wr_cmd_ready", cur_cmd_ready, 1'b1);
        wexp_q.push_back({addr, line});
        @(negedge clk);
        cmd_valid = 1'b0;
        if (pre_busy > 0) cop_busy = 1'b1;
        k = 0; guard = 0;
        while (k < 8 && guard < 64) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                wr_valid = 1'b0;
            end else begin
                wr_valid = 1'b1;
                wr_data  = line[k*32 +: 32];
            end
            #1;
            if (wr_valid && cur_wr_ready) k++;
            guard++;
            if (k < 8) @(negedge clk);
        end
        cop_busy = 1'b0;
        if (k < 8) begin
            wr_valid = 1'b0;
            check("fill_timeout", k, 8);
        end else begin
            @(posedge clk); #1;
            wr_valid = 1'b0;
            check("write_pulse_wren", cur_wren, 1'b1);
            check("write_pulse_busy", cur_busy, 1'b1);
            @(posedge clk); #1;
            check("write_done_wren", cur_wren, 1'b0);
            check("write_done_busy", cur_busy, 1'b0);
            check("write_done_ready", cur_cmd_ready, 1'b1);
        end
    endtask

    task automatic do_read(input logic [7:0] addr, input logic [255:0] line,
                           input bit stall, input bit stray);
        int n;
        int guard;
        logic [31:0] prev;
        bit prev_stall;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_RD_LINE; cmd_addr = addr;
        #1 check("rd_cmd_ready", cur_cmd_ready, 1'b1);
        for (int k = 0; k < 8; k++) exp_q.push_back(line[k*32 +: 32]);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0; guard = 0; prev_stall = 0; prev = '0;
        while (n < 8 && guard < 100) begin
            rd_ready = stall ? (guard % 2 == 1) : 1'b1;
            if (stray) begin
                wr_valid = 1'b1;
                wr_data  = $urandom;
            end
            #1;
            if (cur_rd_valid) begin
                if (prev_stall) check("rd_hold", cur_rd_data, prev);
                if (rd_ready) begin
                    if (exp_q.size() == 0) check("rd_extra_word", 1'b1, 1'b0);
                    else check("rd_word", cur_rd_data, exp_q.pop_front());
                    n++;
                end
                prev_stall = !rd_ready;
                prev = cur_rd_data;
            end
            guard++;
            @(negedge clk);
        end
        rd_ready = 1'b0;
        wr_valid = 1'b0;
        if (n < 8) check("drain_timeout", n, 8);
        #1;
        check("rd_done_valid", cur_rd_valid, 1'b0);
        check("rd_done_busy", cur_busy, 1'b0);
    endtask

    // ---------------- table-driven IDLE vectors ----------------
    typedef struct {
        logic       cmd_valid;
        logic [1:0] op;
        logic       cop_busy;
        logic       exp_ready;
        logic       exp_err;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [255:0] l1, l2, l2b, lr, lr2;

        vecs[0] = '{1'b1, 2'b10, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 2'b00, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 2'b01, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 2'b11, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 2'b00, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 2'b11, 1'b0, 1'b1, 1'b0};

        l1  = mk_line(8'h00);
        l2  = mk_line(8'h40);
        l2b = mk_line(8'hC0);
        lr  = rnd_line();
        lr2 = rnd_line();

        rst_n = 1'b0; preload = 1'b1; sel = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 8'h00;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; cop_busy = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        #1;
        check("rst_state", cur_state, IDLE);
        check("rst_busy", cur_busy, 1'b0);
        check("rst_wren", cur_wren, 1'b0);
        check("rst_err", cur_err, 1'b0);
        check("rst_rd_valid", cur_rd_valid, 1'b0);
        check("rst_wr_ready", cur_wr_ready, 1'b0);
        check("rst_addr", cur_addr, 8'h00);
        check("rst_wdata", cur_wdata, 256'h0);
        check("rst_cmd_ready", cur_cmd_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1; preload = 1'b0;

        // Idle behaviour: gating and illegal opcodes.
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            cmd_valid = vecs[i].cmd_valid; cmd_op = vecs[i].op;
            cmd_addr = 8'hAA; cop_busy = vecs[i].cop_busy;
            #1 check("vec_ready", cur_cmd_ready, vecs[i].exp_ready);
            @(posedge clk); #1;
            check("vec_err", cur_err, vecs[i].exp_err);
            check("vec_state", cur_state, IDLE);
            check("vec_wren", cur_wren, 1'b0);
            cmd_valid = 1'b0; cop_busy = 1'b0;
            @(posedge clk); #1;
            check("vec_err_one_cycle", cur_err, 1'b0);
        end

        // Write line 1, then reads of the result line, plain and stalled.
        do_write(8'd1, l1, 1'b0, 0);
        do_read(8'd3, RES_LINE, 1'b0, 1'b0);
        do_read(8'd3, RES_LINE, 1'b1, 1'b0);

        // Command held off by cop_busy, gaps in the word stream.
        do_write(8'd2, l2, 1'b1, 3);
        do_read(8'd2, l2, 1'b1, 1'b0);

        // Reset after 5 words of a fill.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = OP_WR_LINE; cmd_addr = 8'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_data = $urandom;
            @(negedge clk);
        end
        wr_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_state", cur_state, IDLE);
        check("midrst_busy", cur_busy, 1'b0);
        check("midrst_wr_ready", cur_wr_ready, 1'b0);
        check("midrst_wren", cur_wren, 1'b0);
        check("midrst_addr", cur_addr, 8'h00);
        check("midrst_wdata", cur_wdata, 256'h0);
        check("midrst_rd_data", cur_rd_data, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_write(8'd2, l2b, 1'b0, 0);
        do_read(8'd2, l2b, 1'b0, 1'b0);

        // Back-to-back with a stray write strobe during the readback.
        do_write(8'd1, l1, 1'b0, 0);
        do_write(8'd2, lr, 1'b1, 0);
        do_read(8'd2, lr, 1'b1, 1'b1);
        do_read(8'd1, l1, 1'b0, 1'b0);

        // Same flows through the RD_LAT=3 instance.
        @(negedge clk);
        sel = 1'b1;
        do_read(8'd3, RES_LINE, 1'b0, 1'b0);
        do_read(8'd3, RES_LINE, 1'b1, 1'b0);
        do_write(8'd2, lr2, 1'b1, 2);
        do_read(8'd2, lr2, 1'b1, 1'b1);

        repeat (3) @(negedge clk);
        check("wexp_empty", wexp_q.size(), 0);
        check("exp_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1);
    end

endmodule
